ifu_way0: RTL and testbench
===========================

# ifu_way0

Instruction fetch unit for way 0. It sits between the program counter unit and the decoder. It accepts 8-byte-aligned fetch addresses over a valid/ready handshake, issues reads to a fixed-latency instruction memory, and queues each 64-bit fetch packet with its address and slot mask. It discards all fetched and in-flight work when the pipeline redirects on a jump.

## Interface
- DEPTH, 4: fetch queue entries; power of two, ≥2.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pcValid_i  in  1  fetch address offered by PC unit.
- pcAddr_i  in  32  fetch address.
- pcReady_o  out  1  unit can accept a fetch address this cycle.
- flush_i  in  1  jump redirect (same cycle as PC unit's jump flag); kill all queued and in-flight fetches.
- imemReq_o  out  1  instruction memory read strobe.
- imemAddr_o  out  32  read address, always {pcAddr_i[31:3], 3'b000}.
- imemRdata_i  in  64  read data, valid exactly one cycle after imemReq_o.
- instValid_o  out  1  head packet valid to decoder.
- instAddr_o  out  32  head packet fetch address, original pcAddr_i with bits [1:0] forced to 0.
- instData_o  out  64  head packet data; [31:0] = slot 0, [63:32] = slot 1.
- instMask_o  out  2  valid slots: 2'b11 if addr[2]=0, 2'b10 if addr[2]=1.
- decReady_i  in  1  decoder consumes head packet when instValid_o && decReady_i.

## Operation
- Accept: pcValid_i && pcReady_o. That cycle: imemReq_o=1, imemAddr_o aligned, inflight register set, address/mask latched.
- pcReady_o = ~flush_i && (count + inflight) < DEPTH; uses registered count only, no credit for a same-cycle dequeue.
- Response: cycle after accept, if inflight and no flush that cycle, write {addr, mask, imemRdata_i} at tail; inflight cleared unless a new accept occurs the same cycle. Back-to-back accepts sustain one packet per cycle.
- Dequeue: instValid_o && decReady_i pops head; enqueue and dequeue in same cycle leave count unchanged.
- Flush (highest priority): cycle with flush_i=1: pcReady_o=0, imemReq_o=0, instValid_o=0, no dequeue. At edge: count=0, head=tail=0, inflight=0, so the response arriving next cycle is dropped.
- pcAddr_i[1:0] ignored. No fault generation.
- count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Reset: count=0, pointers=0, inflight=0. Outputs: pcReady_o=1 (once reset deasserts, combinational), imemReq_o=0, imemAddr_o=0, instValid_o=0, instAddr_o=0, instData_o=0, instMask_o=2'b00. Reset mid-operation behaves as flush plus register clear. Response data in the following cycle is ignored.

## Timing
- Accept at cycle N -> memory data at N+1 -> written at end of N+1 -> instValid_o at N+2 (no bypass).
- Full: with DEPTH=4, four outstanding (queued+inflight) -> pcReady_o=0 until a dequeue edge.
- Empty: instValid_o=0, outputs hold last head contents (0 after reset).
- Flush at F: next accept possible at F+1; first post-flush packet visible at F+3 (no bypass).

## Configuration
- IFU_BYPASS_EN defined: when queue empty, inflight response valid, no flush, imemRdata_i/addr/mask drive outputs combinationally with instValid_o=1 at N+1. If decReady_i=1 that cycle, the packet is not written. Otherwise it is enqueued normally.
- Undefined: outputs come only from queue head registers; latency accept-to-valid is 2 cycles; no combinational path from imemRdata_i to outputs.

## Test plan
- Reset, then accept 0x0000_0000 with decReady_i=1 -> imemAddr_o=0x0 at N, instValid_o at N+2 (N+1 with IFU_BYPASS_EN), instAddr_o=0x0, mask 2'b11.
- Accept 0x0000_0104 -> imemAddr_o=0x0000_0100, instAddr_o=0x0000_0104, instMask_o=2'b10.
- decReady_i=0, pcValid_i=1 continuously, DEPTH=4 -> exactly 4 accepts (0x00,0x08,0x10,0x18), then pcReady_o=0. Raise decReady_i -> packets popped in order, pcReady_o returns 1 the cycle after first pop.
- 3 packets queued, inflight set, flush_i pulse -> instValid_o=0 same cycle, next cycle count=0, response data discarded. Accept 0x0000_2000 at F+1 -> first packet out has instAddr_o=0x0000_2000.
- Simultaneous enqueue and dequeue at count=2 for 10 cycles -> count stays 2, output order matches input order, one packet per cycle.
- Assert reset while 2 packets queued and inflight -> next cycle instValid_o=0, all outputs at reset values, stale response ignored.

Source files
------------

// File: rtl/ifu_way0_if.sv
// rtl/ifu_way0_if.sv - fetch unit bus bundle: PC unit, instruction memory and decoder sides
interface ifu_way0_if;
  logic        pcValid_i;
  logic [31:0] pcAddr_i;
  logic        pcReady_o;
  logic        flush_i;
  logic        imemReq_o;
  logic [31:0] imemAddr_o;
  logic [63:0] imemRdata_i;
  logic        instValid_o;
  logic [31:0] instAddr_o;
  logic [63:0] instData_o;
  logic [1:0]  instMask_o;
  logic        decReady_i;

  modport slave (
    input  pcValid_i, pcAddr_i, flush_i, imemRdata_i, decReady_i,
    output pcReady_o, imemReq_o, imemAddr_o, instValid_o, instAddr_o, instData_o, instMask_o
  );

  modport master (
    output pcValid_i, pcAddr_i, flush_i, imemRdata_i, decReady_i,
    input  pcReady_o, imemReq_o, imemAddr_o, instValid_o, instAddr_o, instData_o, instMask_o
  );
endinterface

// File: rtl/ifu_way0.sv
// rtl/ifu_way0.sv - way-0 fetch unit: fixed-latency imem reads into a packet queue with flush
// Optional combinational response bypass when the queue is empty: IFU_BYPASS_EN
module ifu_way0 #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  ifu_way0_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic          r_inflight;
  logic [31:0]   r_req_addr;
  logic [1:0]    r_req_mask;

  logic [31:0]   r_mem_addr [DEPTH];
  logic [63:0]   r_mem_data [DEPTH];
  logic [1:0]    r_mem_mask [DEPTH];

  logic [31:0]   r_last_addr;
  logic [63:0]   r_last_data;
  logic [1:0]    r_last_mask;

  logic [CW-1:0] w_occ;
  logic          w_kill;
  logic          w_ready;
  logic          w_accept;
  logic          w_rsp;
  logic          w_empty;
  logic          w_byp;
  logic          w_valid;
  logic          w_pop;
  logic          w_deq;
  logic          w_enq;
  logic [31:0]   w_out_addr;
  logic [63:0]   w_out_data;
  logic [1:0]    w_out_mask;

  // Occupancy counts the in-flight read so the queue can never overflow on its response.
  assign w_occ    = r_count + CW'(r_inflight);
  assign w_kill   = reset | bus.flush_i;
  assign w_ready  = ~w_kill & (w_occ < CW'(DEPTH));
  assign w_accept = bus.pcValid_i & w_ready;
  assign w_rsp    = r_inflight & ~w_kill;
  assign w_empty  = (r_count == '0);

`ifdef IFU_BYPASS_EN
  assign w_byp = w_empty & w_rsp;

  always_comb begin
    w_out_addr = r_last_addr;
    w_out_data = r_last_data;
    w_out_mask = r_last_mask;
    if (w_byp) begin
      w_out_addr = r_req_addr;
      w_out_data = bus.imemRdata_i;
      w_out_mask = r_req_mask;
    end else if (!w_empty) begin
      w_out_addr = r_mem_addr[r_head];
      w_out_data = r_mem_data[r_head];
      w_out_mask = r_mem_mask[r_head];
    end
  end
`else
  assign w_byp = 1'b0;

  always_comb begin
    w_out_addr = r_last_addr;
    w_out_data = r_last_data;
    w_out_mask = r_last_mask;
    if (!w_empty) begin
      w_out_addr = r_mem_addr[r_head];
      w_out_data = r_mem_data[r_head];
      w_out_mask = r_mem_mask[r_head];
    end
  end
`endif

  assign w_valid = ~w_kill & (~w_empty | w_byp);
  assign w_pop   = w_valid & bus.decReady_i;
  assign w_deq   = w_pop & ~w_empty;
  // A bypassed packet taken by the decoder in the same cycle never occupies a slot.
  assign w_enq   = w_rsp & ~(w_byp & bus.decReady_i);

  assign bus.pcReady_o   = w_ready;
  assign bus.imemReq_o   = w_accept;
  assign bus.imemAddr_o  = reset ? 32'h0 : {bus.pcAddr_i[31:3], 3'b000};
  assign bus.instValid_o = w_valid;
  assign bus.instAddr_o  = w_out_addr;
  assign bus.instData_o  = w_out_data;
  assign bus.instMask_o  = w_out_mask;

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_count    <= r_count + CW'(w_enq) - CW'(w_deq);
      r_inflight <= w_accept;
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_addr <= 32'h0;
      r_req_mask <= 2'b00;
    end else if (w_accept) begin
      r_req_addr <= {bus.pcAddr_i[31:2], 2'b00};
      r_req_mask <= bus.pcAddr_i[2] ? 2'b10 : 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_addr[r_tail] <= r_req_addr;
      r_mem_data[r_tail] <= bus.imemRdata_i;
      r_mem_mask[r_tail] <= r_req_mask;
    end
  end

  // Outputs keep showing the most recently consumed packet while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_addr <= 32'h0;
      r_last_data <= 64'h0;
      r_last_mask <= 2'b00;
    end else if (w_pop) begin
      r_last_addr <= w_out_addr;
      r_last_data <= w_out_data;
      r_last_mask <= w_out_mask;
    end
  end
endmodule

// File: tb/tb_ifu_way0.sv
// tb/tb_ifu_way0.sv - scoreboard bench for ifu_way0 with a fixed-latency memory model
module tb_ifu_way0;
  logic clk;
  logic reset;

  ifu_way0_if dif ();

  ifu_way0 #(.DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  mask;
    logic [63:0] data;
  } pkt_t;

  pkt_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  bit auto_inc = 1'b0;

  logic        m_req;
  logic [31:0] m_addr;

  logic        s_valid, s_ready, s_req, s_pop, s_acc;
  logic [31:0] s_iaddr, s_addr;
  logic [63:0] s_data;
  logic [1:0]  s_mask;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h1357_9BDF, ~a};
  endfunction

  always @(posedge clk) begin
    m_req  <= dif.imemReq_o;
    m_addr <= dif.imemAddr_o;
  end

  assign dif.imemRdata_i = m_req ? mem_word(m_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    pkt_t p;
    pkt_t e;
    @(negedge clk);
    s_valid = dif.instValid_o;
    s_ready = dif.pcReady_o;
    s_req   = dif.imemReq_o;
    s_iaddr = dif.imemAddr_o;
    s_addr  = dif.instAddr_o;
    s_data  = dif.instData_o;
    s_mask  = dif.instMask_o;
    s_pop   = s_valid && dif.decReady_i;
    s_acc   = dif.pcValid_i && s_ready;
    if (reset || dif.flush_i) begin
      check("kill_valid", 64'(s_valid), 64'(0));
      check("kill_ready", 64'(s_ready), 64'(0));
      check("kill_req",   64'(s_req),   64'(0));
      sb.delete();
    end else begin
      if (s_pop) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pkt_addr", 64'(s_addr), 64'(e.addr));
          check("pkt_data", s_data, e.data);
          check("pkt_mask", 64'(s_mask), 64'(e.mask));
        end
      end
      if (s_acc) begin
        check("imem_req",  64'(s_req),   64'(1));
        check("imem_addr", 64'(s_iaddr), 64'({dif.pcAddr_i[31:3], 3'b000}));
        p.addr = {dif.pcAddr_i[31:2], 2'b00};
        p.mask = dif.pcAddr_i[2] ? 2'b10 : 2'b11;
        p.data = mem_word({dif.pcAddr_i[31:3], 3'b000});
        sb.push_back(p);
      end
    end
    n_acc += int'(s_acc);
    n_pop += int'(s_pop);
    @(posedge clk);
    #1;
    if (s_acc && auto_inc) dif.pcAddr_i = dif.pcAddr_i + 32'd8;
  endtask

  task automatic drain();
    dif.pcValid_i  = 1'b0;
    dif.decReady_i = 1'b1;
    dif.flush_i    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 64'(seen), 64'(1));
  endtask

  int a0;
  int p0;

  initial begin
    reset          = 1'b1;
    dif.pcValid_i  = 1'b0;
    dif.pcAddr_i   = 32'h0;
    dif.flush_i    = 1'b0;
    dif.decReady_i = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    tick();
    check("rst_ready", 64'(s_ready), 64'(1));
    check("rst_valid", 64'(s_valid), 64'(0));
    check("rst_req",   64'(s_req),   64'(0));
    check("rst_addr",  64'(s_addr),  64'(0));
    check("rst_data",  s_data,       64'(0));
    check("rst_mask",  64'(s_mask),  64'(0));

    // first fetch latency
    dif.pcValid_i  = 1'b1;
    dif.pcAddr_i   = 32'h0;
    dif.decReady_i = 1'b1;
    tick();
    check("t1_req",  64'(s_req),   64'(1));
    check("t1_imem", 64'(s_iaddr), 64'(0));
    dif.pcValid_i = 1'b0;
    tick();
    check("t1_valid_n1", 64'(s_valid), 64'(BYP));
    if (!BYP) begin
      tick();
      check("t1_valid_n2", 64'(s_valid), 64'(1));
    end
    check("t1_addr", 64'(s_addr), 64'(0));
    check("t1_mask", 64'(s_mask), 64'(2'b11));
    drain();

    // unaligned address, slot 1 only
    dif.pcValid_i = 1'b1;
    dif.pcAddr_i  = 32'h0000_0104;
    tick();
    check("t2_imem", 64'(s_iaddr), 64'(32'h0000_0100));
    dif.pcValid_i = 1'b0;
    wait_valid("t2_seen");
    check("t2_addr", 64'(s_addr), 64'(32'h0000_0104));
    check("t2_mask", 64'(s_mask), 64'(2'b10));
    drain();

    // fill to full with the decoder stalled
    a0 = n_acc;
    auto_inc       = 1'b1;
    dif.pcAddr_i   = 32'h0;
    dif.pcValid_i  = 1'b1;
    dif.decReady_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("full_accepts", 64'(n_acc - a0), 64'(4));
    check("full_ready",   64'(s_ready),    64'(0));
    check("full_next",    64'(dif.pcAddr_i), 64'(32'h20));
    dif.pcValid_i  = 1'b0;
    dif.decReady_i = 1'b1;
    tick();
    check("full_pop",      64'(s_pop),   64'(1));
    check("full_ready_p0", 64'(s_ready), 64'(0));
    tick();
    check("full_ready_p1", 64'(s_ready), 64'(1));
    drain();

    // flush with three queued and one in flight
    dif.pcAddr_i   = 32'h0000_1000;
    dif.pcValid_i  = 1'b1;
    dif.decReady_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    auto_inc      = 1'b0;
    dif.pcValid_i = 1'b0;
    dif.flush_i   = 1'b1;
    tick();
    dif.flush_i    = 1'b0;
    dif.pcValid_i  = 1'b1;
    dif.pcAddr_i   = 32'h0000_2000;
    dif.decReady_i = 1'b1;
    tick();
    check("fl_accept", 64'(s_acc),   64'(1));
    check("fl_empty",  64'(s_valid), 64'(0));
    dif.pcValid_i = 1'b0;
    tick();
    check("fl_f2_valid", 64'(s_valid), 64'(BYP));
    if (!BYP) begin
      tick();
      check("fl_f3_valid", 64'(s_valid), 64'(1));
    end
    check("fl_addr", 64'(s_addr), 64'(32'h0000_2000));
    drain();

    // steady enqueue+dequeue at two queued
    auto_inc       = 1'b1;
    dif.pcAddr_i   = 32'h0000_3000;
    dif.pcValid_i  = 1'b1;
    dif.decReady_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    a0 = n_acc;
    p0 = n_pop;
    dif.decReady_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("st_accepts", 64'(n_acc - a0), 64'(10));
    check("st_pops",    64'(n_pop - p0), 64'(10));
    auto_inc = 1'b0;
    drain();

    // reset mid-operation
    auto_inc       = 1'b1;
    dif.pcAddr_i   = 32'h0000_4000;
    dif.pcValid_i  = 1'b1;
    dif.decReady_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    auto_inc      = 1'b0;
    dif.pcValid_i = 1'b0;
    reset         = 1'b1;
    tick();
    reset          = 1'b0;
    dif.decReady_i = 1'b1;
    tick();
    check("mr_valid", 64'(s_valid), 64'(0));
    check("mr_ready", 64'(s_ready), 64'(1));
    check("mr_addr",  64'(s_addr),  64'(0));
    check("mr_data",  s_data,       64'(0));
    check("mr_mask",  64'(s_mask),  64'(0));
    tick();
    check("mr_stale", 64'(s_valid), 64'(0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
